// File: rtl/i4001_rom_arbiter.sv
// +----------------------------------------------------------------------+
// | i4001_rom_arbiter: shares one single-port RAM between i4001 fetches  |
// | (strict priority) and a request/ack host port. Revision: 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module i4001_rom_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int ROM_CHIPS = 16
) (
  input  logic              sysclk,
  input  logic              poc_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [7:0]        rom_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
  output logic              host_err,
  output logic [7:0]        host_rdata,
  input  logic              wp,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  state_t r_state;
  logic   r_prev_ack;
  logic   r_fetch_d;

  logic   w_chip_oob;
  logic   w_reject;
  logic   w_host_go;

  // Chip number is everything above the 8-bit in-chip byte offset.
  assign w_chip_oob = (32'(host_addr[ADDR_W-1:8]) >= 32'(ROM_CHIPS));
  assign w_reject   = w_chip_oob | (host_we & wp);
  assign w_host_go  = (r_state == ST_ISSUE) & host_req & ~fetch_req & ~w_reject;

  always_comb begin
    mem_en    = poc_n & (fetch_req | w_host_go);
    mem_we    = poc_n & w_host_go & host_we;
    mem_addr  = fetch_req ? fetch_addr : host_addr;
    mem_wdata = host_wdata;
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      r_state    <= ST_IDLE;
      r_prev_ack <= 1'b0;
      r_fetch_d  <= 1'b0;
      rom_data   <= 8'h00;
      host_rdata <= 8'h00;
      host_ack   <= 1'b0;
      host_err   <= 1'b0;
    end else begin
      r_fetch_d  <= fetch_req;
      r_prev_ack <= (r_state == ST_ACK);
      host_ack   <= 1'b0;
      if (r_fetch_d) begin
        rom_data <= mem_rdata;
      end

      case (r_state)
        ST_IDLE: begin
          // One dead cycle after ACK keeps a still-held request from re-granting.
          if (host_req && !r_prev_ack) begin
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!host_req) begin
            r_state <= ST_IDLE;
          end else if (fetch_req) begin
            r_state <= ST_ISSUE;
          end else if (w_reject) begin
            r_state  <= ST_ACK;
            host_ack <= 1'b1;
            host_err <= 1'b1;
          end else if (host_we) begin
            r_state  <= ST_ACK;
            host_ack <= 1'b1;
            host_err <= 1'b0;
          end else begin
            r_state <= ST_RDWAIT;
          end
        end
        ST_RDWAIT: begin
          host_rdata <= mem_rdata;
          r_state    <= ST_ACK;
          host_ack   <= 1'b1;
          host_err   <= 1'b0;
        end
        ST_ACK: begin
          r_state  <= ST_IDLE;
          host_err <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/i4001_rom_arbiter.md
I4001_ROM_ARBITER -- requirements
Module: i4001_rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: ROM byte address width; addr[11:8] is the ROM chip number and addr[7:0] the byte within the chip.
REQ-002 Parameter ROM_CHIPS, default 16: number of populated ROM chips; a chip number >= ROM_CHIPS is out of range.
REQ-003 sysclk  in  1  single system clock; all state changes on its rising edge.
REQ-004 poc_n  in  1  asynchronous active-low reset.
REQ-005 fetch_req  in  1  one-cycle pulse from the i4001 timing logic requesting a ROM read.
REQ-006 fetch_addr  in  ADDR_W  fetch address, valid in the cycle fetch_req=1.
REQ-007 rom_data  out  8  fetched byte returned to the i4001 bus.
REQ-008 host_req  in  1  host access request; a level held until host_ack.
REQ-009 host_we  in  1  1=write, 0=read; stable while host_req=1.
REQ-010 host_addr  in  ADDR_W  host address; stable while host_req=1.
REQ-011 host_wdata  in  8  host write data; stable while host_req=1.
REQ-012 host_ack  out  1  one-cycle completion pulse.
REQ-013 host_err  out  1  valid with host_ack: the request was rejected and no memory access occurred.
REQ-014 host_rdata  out  8  read data, valid with host_ack on an accepted read, held until the next accepted read.
REQ-015 wp  in  1  write protect: when 1, host writes are rejected.
REQ-016 mem_en, mem_we  out  1 each  single-port block RAM enable and write strobe.
REQ-017 mem_addr  out  ADDR_W; mem_wdata  out  8  RAM address and write data.
REQ-018 mem_rdata  in  8  RAM read data, valid exactly 1 cycle after mem_en=1 with mem_we=0.

Function
REQ-019 Fetch has strict priority: in the cycle fetch_req=1, the block SHALL drive mem_en=1, mem_we=0 and mem_addr=fetch_addr combinationally, regardless of host state.
REQ-020 rom_data SHALL load mem_rdata on the cycle after a fetch issue, so it is valid 2 cycles after fetch_req, and SHALL hold until the next fetch load.
REQ-021 The host FSM SHALL have the states IDLE, ISSUE, RDWAIT and ACK.
REQ-022 IDLE -> ISSUE when host_req=1 and the previous cycle was not ACK; this sets a one-cycle gap so a held host_req is not re-granted.
REQ-023 In ISSUE, if fetch_req=1 the FSM SHALL stay in ISSUE with no host memory access, deferring the host access by one cycle for each such conflict.
REQ-024 In ISSUE with fetch_req=0, when the chip number >= ROM_CHIPS, or when host_we=1 and wp=1, the FSM SHALL go to ACK with host_err=1 and no mem_en.
REQ-025 In ISSUE with fetch_req=0, an accepted write SHALL drive mem_en=1, mem_we=1, mem_addr=host_addr and mem_wdata=host_wdata, then go to ACK.
REQ-026 In ISSUE with fetch_req=0, an accepted read SHALL drive mem_en=1, mem_we=0 and mem_addr=host_addr, then go to RDWAIT.
REQ-027 RDWAIT SHALL capture mem_rdata into host_rdata and go to ACK; a fetch_req in RDWAIT is issued normally, because the RAM is pipelined.
REQ-028 ACK SHALL pulse host_ack=1 for one cycle, with host_err as decided in ISSUE, and return to IDLE.
REQ-029 Host latency with no fetch conflict: a write SHALL acknowledge 2 cycles after host_req rises, and a read 3 cycles after.
REQ-030 If host_req drops before ACK, the FSM SHALL complete the access already in progress and still pulse host_ack; an access not yet issued in ISSUE SHALL be abandoned and the FSM returns to IDLE without host_ack.
REQ-031 mem_we SHALL never be 1 in a cycle where fetch_req=1.
REQ-032 mem_en SHALL be 0 in any cycle with no fetch issue and no host issue; mem_addr and mem_wdata are don't-care then.
REQ-033 Wrap-around: address 12'hFFF is legal when ROM_CHIPS=16, and no address arithmetic is performed.

Reset
REQ-034 While poc_n=0, asynchronously: FSM=IDLE, rom_data=8'h00, host_rdata=8'h00, host_ack=0, host_err=0.
REQ-035 While poc_n=0, the memory outputs SHALL be mem_en=0 and mem_we=0.
REQ-036 Reset asserted mid-access SHALL abort the access without host_ack; a write already strobed is not rolled back.

Verification
REQ-037 Fetch path: fetch_req with fetch_addr=12'h123 and mem holding 8'hA5 there -> rom_data=8'hA5 exactly 2 cycles later, held until the next fetch.
REQ-038 Host write then read: write 8'h3C to 12'h045 with wp=0 -> host_ack 2 cycles later with host_err=0; read 12'h045 -> host_ack 3 cycles later with host_rdata=8'h3C.
REQ-039 Conflict: host read pending in ISSUE while fetch_req pulses for 3 consecutive cycles -> the host issue is delayed 3 cycles, fetch data is correct, and mem_we=0 throughout.
REQ-040 Error cases, run both with ROM_CHIPS=4:
- write with wp=1 -> host_ack with host_err=1 and no mem_en;
- access to 12'h5xx -> host_ack with host_err=1.
REQ-041 Reset: poc_n low in RDWAIT -> no host_ack, all outputs at reset values; after release a new host read completes normally.
